// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
// seg7_scan_driver: time-multiplexed driver for an NDIG-digit common-anode 7-segment
// display. Scans leftmost digit first, 16 sub-phases per digit slot, with sub-phase 0
// always dark as an anti-ghosting guard and sub-phases 1..BRIGHT lit (PWM brightness).
// VALUE/DP are captured into a shadow copy only at frame start, so a frame never mixes
// two values. Optional leading-zero blanking is compiled in with `define SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int NDIG       = 4,
    parameter int PRESCALE   = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [4*NDIG-1:0]   VALUE,
    input  logic [NDIG-1:0]     DP,
    input  logic [3:0]          BRIGHT,
`ifdef SEG7_LZB_EN
    input  logic                LZB,
`endif
    output logic [7:0]          SEG,
    output logic [NDIG-1:0]     DIG,
    output logic                FRAME
);

    localparam int              PW    = $clog2(PRESCALE);
    localparam int              KW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0]   PLAST = PW'(PRESCALE - 1);
    localparam logic [KW-1:0]   KLAST = KW'(NDIG - 1);
    localparam logic            INV   = (ACTIVE_LOW != 0);

    // Hex font, logical active-high, {A,B,C,D,E,F,G,Dp} with Dp left clear.
    function automatic logic [7:0] font(input logic [3:0] h);
        logic [7:0] s;
        unique case (h)
            4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
            4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  4'hF: s = 8'h8E;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Scan state and frame shadow
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic [3:0]         sub_q, sub_d;
    logic [KW-1:0]      k_q, k_d;
    logic [4*NDIG-1:0]  shadow_val_q;
    logic [NDIG-1:0]    shadow_dp_q;
    logic [7:0]         seg_q, seg_d;
    logic [NDIG-1:0]    dig_q, dig_d;
    logic               frame_q;

    logic               tick;
    logic               frame_start;
    logic [KW-1:0]      dsel;
    logic [3:0]         nib;
    logic               dpb;
    logic [NDIG-1:0]    blank_mask;
    logic               lzb_run;
    logic               lit;
    logic [7:0]         seg_log;
    logic [NDIG-1:0]    dig_log;

    // Counter next-state: prescaler, sub-phase and slot index.
    always_comb begin
        tick        = (pcnt_q == PLAST);
        frame_start = tick && (sub_q == 4'd15) && (k_q == KLAST);
        pcnt_d      = tick ? '0 : pcnt_q + 1'b1;
        sub_d       = tick ? sub_q + 4'd1 : sub_q;
        k_d         = k_q;
        if (tick && (sub_q == 4'd15)) begin
            k_d = (k_q == KLAST) ? '0 : k_q + 1'b1;
        end
    end

    // Leading-zero mask: digits from the left stay dark while their nibble and DP are both 0.
    always_comb begin
        blank_mask = '0;
        lzb_run    = 1'b0;
`ifdef SEG7_LZB_EN
        lzb_run = LZB;
        for (int i = NDIG - 1; i >= 1; i--) begin
            lzb_run       = lzb_run && (shadow_val_q[4*i +: 4] == 4'h0) && !shadow_dp_q[i];
            blank_mask[i] = lzb_run;
        end
`endif
    end

    // Output decode for the current slot: slot k shows digit NDIG-1-k.
    always_comb begin
        dsel    = KLAST - k_q;
        nib     = 4'h0;
        dpb     = 1'b0;
        lit     = 1'b0;
        dig_log = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (KW'(i) == dsel) begin
                nib = shadow_val_q[4*i +: 4];
                dpb = shadow_dp_q[i];
                lit = (sub_q != 4'd0) && (sub_q <= BRIGHT) && !blank_mask[i];
            end
        end
        for (int i = 0; i < NDIG; i++) begin
            dig_log[i] = lit && (KW'(i) == dsel);
        end
        seg_log = lit ? (font(nib) | {7'b0, dpb}) : 8'h00;
        seg_d   = INV ? ~seg_log : seg_log;
        dig_d   = INV ? ~dig_log : dig_log;
    end

    // State, shadow latch and registered pin outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt_q       <= '0;
            sub_q        <= '0;
            k_q          <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            frame_q      <= 1'b0;
            seg_q        <= INV ? 8'hFF : 8'h00;
            dig_q        <= INV ? '1 : '0;
        end else begin
            pcnt_q  <= pcnt_d;
            sub_q   <= sub_d;
            k_q     <= k_d;
            frame_q <= frame_start;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            if (frame_start) begin
                shadow_val_q <= VALUE;
                shadow_dp_q  <= DP;
            end
        end
    end

    assign SEG   = seg_q;
    assign DIG   = dig_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
// Bench for seg7_scan_driver with NDIG=4, PRESCALE=2, ACTIVE_LOW=1 (slot 32, frame 128).
// Expected per-slot appearance is queued when stimulus is applied and drained slot by
// slot as the display scans.
module tb_seg7_scan_driver;

    localparam int NDIG = 4;
    localparam int PRESCALE = 2;
    localparam int ACTIVE_LOW = 1;
    localparam int SLOT = 32;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] VALUE;
    logic [3:0]  DP;
    logic [3:0]  BRIGHT;
    logic [7:0]  SEG;
    logic [3:0]  DIG;
    logic        FRAME;
`ifdef SEG7_LZB_EN
    logic        LZB;
`endif

    seg7_scan_driver #(.NDIG(NDIG), .PRESCALE(PRESCALE), .ACTIVE_LOW(ACTIVE_LOW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .VALUE (VALUE),
        .DP    (DP),
        .BRIGHT(BRIGHT),
`ifdef SEG7_LZB_EN
        .LZB   (LZB),
`endif
        .SEG   (SEG),
        .DIG   (DIG),
        .FRAME (FRAME)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] dig;
        logic [7:0] seg;
        int         lit;
        string      tag;
    } slot_t;

    slot_t sb[$];

    logic [7:0] FONT [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    task automatic push_digit(input int d, input logic [3:0] hex, input logic dp,
                              input int lit, input string tag);
        slot_t e;
        logic [3:0] m;
        m = 4'b0001 << d;
        e.dig = ~m;
        e.seg = ~(FONT[hex] | {7'b0, dp});
        e.lit = lit;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_dark(input string tag);
        slot_t e;
        e.dig = 4'hF;
        e.seg = 8'hFF;
        e.lit = 0;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Drain n queued slots, one 32-cycle window each, starting at the next negedge.
    task automatic observe_slots(input int n);
        slot_t e;
        int lit, match, bad, first;
        for (int s = 0; s < n; s++) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_empty: got 0 entries want >=1");
                return;
            end
            e = sb.pop_front();
            lit = 0; match = 0; bad = 0; first = -1;
            for (int c = 0; c < SLOT; c++) begin
                @(negedge CLK);
                if (DIG !== 4'hF) begin
                    lit++;
                    if (first < 0) first = c;
                    if (DIG === e.dig && SEG === e.seg) match++;
                    else bad++;
                end else if (SEG !== 8'hFF) begin
                    bad++;
                end
            end
            n_cmp++;
            if (lit !== e.lit) begin
                n_bad++;
                $display("FAIL %s_lit_cycles: got %0d want %0d", e.tag, lit, e.lit);
            end
            n_cmp++;
            if (match !== e.lit) begin
                n_bad++;
                $display("FAIL %s_pattern: got %0d matching cycles want %0d (DIG=%b SEG=%h)",
                         e.tag, match, e.lit, e.dig, e.seg);
            end
            n_cmp++;
            if (bad !== 0) begin
                n_bad++;
                $display("FAIL %s_stray: got %0d wrong cycles want 0", e.tag, bad);
            end
            if (e.lit > 0) begin
                n_cmp++;
                if (first !== 2) begin
                    n_bad++;
                    $display("FAIL %s_guard: got first lit cycle %0d want 2", e.tag, first);
                end
            end
        end
    endtask

    // Advance at least one cycle, then until FRAME is seen (bounded).
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (FRAME !== 1'b1 && n < 400);
        n_cmp++;
        if (FRAME !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_frame_timeout: got FRAME=%b want 1 within 400 cycles", tag, FRAME);
        end
    endtask

    task automatic test_reset;
        int n;
        RST = 1'b1; VALUE = 16'h8492; DP = 4'b0000; BRIGHT = 4'd15;
`ifdef SEG7_LZB_EN
        LZB = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (SEG !== 8'hFF) begin n_bad++; $display("FAIL reset_seg: got %h want ff", SEG); end
        n_cmp++;
        if (DIG !== 4'hF) begin n_bad++; $display("FAIL reset_dig: got %b want 1111", DIG); end
        n_cmp++;
        if (FRAME !== 1'b0) begin n_bad++; $display("FAIL reset_frame: got %b want 0", FRAME); end
        RST = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (FRAME !== 1'b1 && n < 400);
        n_cmp++;
        if (n !== 128) begin
            n_bad++;
            $display("FAIL first_frame_delay: got %0d cycles want 128", n);
        end
    endtask

    task automatic test_scan;
        push_digit(3, 4'h8, 1'b0, 30, "scan_d3");
        push_digit(2, 4'h4, 1'b0, 30, "scan_d2");
        push_digit(1, 4'h9, 1'b0, 30, "scan_d1");
        push_digit(0, 4'h2, 1'b0, 30, "scan_d0");
        observe_slots(4);
        n_cmp++;
        if (FRAME !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_period: got FRAME=%b want 1 after 128 cycles", FRAME);
        end
    endtask

    task automatic test_frame_latch;
        push_digit(3, 4'h8, 1'b0, 30, "latch_old_d3");
        observe_slots(1);
        VALUE = 16'h1234;
        push_digit(2, 4'h4, 1'b0, 30, "latch_old_d2");
        push_digit(1, 4'h9, 1'b0, 30, "latch_old_d1");
        push_digit(0, 4'h2, 1'b0, 30, "latch_old_d0");
        observe_slots(3);
        n_cmp++;
        if (FRAME !== 1'b1) begin
            n_bad++;
            $display("FAIL latch_frame_edge: got FRAME=%b want 1", FRAME);
        end
        push_digit(3, 4'h1, 1'b0, 30, "latch_new_d3");
        push_digit(2, 4'h2, 1'b0, 30, "latch_new_d2");
        push_digit(1, 4'h3, 1'b0, 30, "latch_new_d1");
        push_digit(0, 4'h4, 1'b0, 30, "latch_new_d0");
        observe_slots(4);
    endtask

    task automatic test_brightness;
        BRIGHT = 4'd0;
        for (int d = 0; d < 4; d++) push_dark("bright0");
        observe_slots(4);
        BRIGHT = 4'd4;
        push_digit(3, 4'h1, 1'b0, 8, "bright4_d3");
        push_digit(2, 4'h2, 1'b0, 8, "bright4_d2");
        push_digit(1, 4'h3, 1'b0, 8, "bright4_d1");
        push_digit(0, 4'h4, 1'b0, 8, "bright4_d0");
        observe_slots(4);
    endtask

    task automatic test_dp;
        DP = 4'b0001;
        BRIGHT = 4'd15;
        wait_frame("dp");
        push_digit(3, 4'h1, 1'b0, 30, "dp_d3");
        push_digit(2, 4'h2, 1'b0, 30, "dp_d2");
        push_digit(1, 4'h3, 1'b0, 30, "dp_d1");
        push_digit(0, 4'h4, 1'b1, 30, "dp_d0");
        observe_slots(4);
    endtask

    task automatic test_mid_reset;
        push_digit(3, 4'h1, 1'b0, 30, "pre_rst_d3");
        push_digit(2, 4'h2, 1'b0, 30, "pre_rst_d2");
        observe_slots(2);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++;
        if (SEG !== 8'hFF) begin n_bad++; $display("FAIL midrst_seg: got %h want ff", SEG); end
        n_cmp++;
        if (DIG !== 4'hF) begin n_bad++; $display("FAIL midrst_dig: got %b want 1111", DIG); end
        n_cmp++;
        if (FRAME !== 1'b0) begin n_bad++; $display("FAIL midrst_frame: got %b want 0", FRAME); end
        push_digit(3, 4'h0, 1'b0, 30, "zeros_d3");
        push_digit(2, 4'h0, 1'b0, 30, "zeros_d2");
        push_digit(1, 4'h0, 1'b0, 30, "zeros_d1");
        push_digit(0, 4'h0, 1'b0, 30, "zeros_d0");
        observe_slots(4);
        n_cmp++;
        if (FRAME !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_restart_frame: got FRAME=%b want 1", FRAME);
        end
    endtask

`ifdef SEG7_LZB_EN
    task automatic test_lzb;
        LZB = 1'b1; VALUE = 16'h0042; DP = 4'b0000;
        wait_frame("lzb42");
        push_dark("lzb42_d3");
        push_dark("lzb42_d2");
        push_digit(1, 4'h4, 1'b0, 30, "lzb42_d1");
        push_digit(0, 4'h2, 1'b0, 30, "lzb42_d0");
        observe_slots(4);
        VALUE = 16'h0000;
        wait_frame("lzb0");
        push_dark("lzb0_d3");
        push_dark("lzb0_d2");
        push_dark("lzb0_d1");
        push_digit(0, 4'h0, 1'b0, 30, "lzb0_d0");
        observe_slots(4);
        VALUE = 16'h0042; DP = 4'b0100;
        wait_frame("lzbdp");
        push_dark("lzbdp_d3");
        push_digit(2, 4'h0, 1'b1, 30, "lzbdp_d2");
        push_digit(1, 4'h4, 1'b0, 30, "lzbdp_d1");
        push_digit(0, 4'h2, 1'b0, 30, "lzbdp_d0");
        observe_slots(4);
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_frame_latch();
        test_brightness();
        test_dp();
        test_mid_reset();
`ifdef SEG7_LZB_EN
        test_lzb();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
